// File: rtl/cmp_arb_pkg.sv
// Shared definitions for the round-robin compare arbiter.
package cmp_arb_pkg;
  localparam int NREQ = 4;
  localparam int ID_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } state_t;
endpackage

// File: rtl/n_bit_comparator.sv
// Unsigned magnitude comparator; exactly one of lt/gt/eq is high.
module n_bit_comparator #(
  parameter int BIT = 16
) (
  input  logic [BIT-1:0] a,
  input  logic [BIT-1:0] b,
  output logic           lt,
  output logic           gt,
  output logic           eq
);
  assign lt = (a < b);
  assign gt = (a > b);
  assign eq = (a == b);
endmodule

// File: rtl/cmp_arbiter.sv
// Four requesters share one comparator; round-robin grant, one transaction in flight.
module cmp_arbiter
  import cmp_arb_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  output logic [ID_W-1:0]       rsp_id,
  output logic                  rsp_lt,
  output logic                  rsp_gt,
  output logic                  rsp_eq,
  input  logic                  rsp_ready,
  output logic                  busy
);
  state_t            state;
  logic [ID_W-1:0]   last_id;
  logic [WIDTH-1:0]  op_a, op_b;
  logic [ID_W-1:0]   op_id;
  logic [ID_W-1:0]   pick, idx;
  logic              found;
  logic              c_lt, c_gt, c_eq;

  // Round-robin search starting after last_id; k=1 is visited last so it wins.
  always_comb begin
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = last_id + ID_W'(k);
      if (req_valid[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  // Accept strobe only in IDLE and never while reset is asserted.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++)
      req_ready[i] = (state == IDLE) && !rst && found && (pick == ID_W'(i));
  end

  assign busy = (state != IDLE);

  n_bit_comparator #(.BIT(WIDTH)) u_cmp (
    .a  (op_a),
    .b  (op_b),
    .lt (c_lt),
    .gt (c_gt),
    .eq (c_eq)
  );

  // Control FSM: latch on grant, register compare result, hold until consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last_id   <= ID_W'(NREQ - 1);
      op_a      <= '0;
      op_b      <= '0;
      op_id     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_lt    <= 1'b0;
      rsp_gt    <= 1'b0;
      rsp_eq    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (found) begin
          op_a  <= req_a[int'(pick)*WIDTH +: WIDTH];
          op_b  <= req_b[int'(pick)*WIDTH +: WIDTH];
          op_id <= pick;
          state <= CMP;
        end
        CMP: begin
          rsp_valid <= 1'b1;
          rsp_id    <= op_id;
          rsp_lt    <= c_lt;
          rsp_gt    <= c_gt;
          rsp_eq    <= c_eq;
          state     <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          last_id   <= rsp_id;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cmp_arbiter.sv
// Directed and randomized checks of cmp_arbiter.
module tb_cmp_arbiter;
  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    req_valid;
  logic [4*W-1:0] req_a, req_b;
  logic [3:0]    req_ready;
  logic          rsp_valid;
  logic [1:0]    rsp_id;
  logic          rsp_lt, rsp_gt, rsp_eq;
  logic          rsp_ready;
  logic          busy;

  int checks = 0;
  int errors = 0;

  typedef struct { int id; logic [W-1:0] a; logic [W-1:0] b; } txn_t;
  txn_t sb[$];

  always #5 clk = ~clk;

  cmp_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_lt(rsp_lt), .rsp_gt(rsp_gt), .rsp_eq(rsp_eq),
    .rsp_ready(rsp_ready), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  initial begin
    int exp_id [5];
    logic [3:0] e;
    logic el [4];
    logic eg [4];
    logic ee [4];
    int n_tx, n_rsp, n_cyc, gid;
    txn_t t;

    rst = 1'b1; req_valid = 4'b1111; req_a = '0; req_b = '0; rsp_ready = 1'b0;

    // Reset state; ready stays low under reset even with all valid
    cyc(); cyc();
    chk("rst_ready", req_ready, 4'b0000);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_flags", {rsp_lt, rsp_gt, rsp_eq}, 3'b000);

    // Single request, equal operands
    rst = 1'b0; req_valid = 4'b0001; set_op(0, 16'h1234, 16'h1234);
    #1 chk("single_ready", req_ready, 4'b0001);
    cyc(); req_valid = 4'b0000;
    #1 chk("single_cmp_busy", busy, 1);
    chk("single_cmp_nrsp", rsp_valid, 0);
    cyc();
    chk("single_rsp_valid", rsp_valid, 1);
    chk("single_rsp_id", rsp_id, 0);
    chk("single_flags", {rsp_lt, rsp_gt, rsp_eq}, 3'b001);
    rsp_ready = 1'b1;
    cyc();
    chk("single_drop", rsp_valid, 0);
    chk("single_idle", busy, 0);

    // All four valid: grant order 0,1,2,3,0
    rst = 1'b1; cyc(); rst = 1'b0;
    set_op(0, 16'h0005, 16'h0009); el[0] = 1; eg[0] = 0; ee[0] = 0;
    set_op(1, 16'h0009, 16'h0005); el[1] = 0; eg[1] = 1; ee[1] = 0;
    set_op(2, 16'h0007, 16'h0007); el[2] = 0; eg[2] = 0; ee[2] = 1;
    set_op(3, 16'h0000, 16'hFFFF); el[3] = 1; eg[3] = 0; ee[3] = 0;
    exp_id = '{0, 1, 2, 3, 0};
    req_valid = 4'b1111; rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      e = 4'b0001 << exp_id[k];
      #1 chk("rr_ready", req_ready, e);
      cyc(); cyc();
      chk("rr_rsp_valid", rsp_valid, 1);
      chk("rr_rsp_id", rsp_id, exp_id[k]);
      chk("rr_flags", {rsp_lt, rsp_gt, rsp_eq}, {el[exp_id[k]], eg[exp_id[k]], ee[exp_id[k]]});
      cyc();
    end
    req_valid = 4'b0000;

    // Backpressure: result held while rsp_ready low, no new grant
    req_valid = 4'b0100; set_op(2, 16'hFFFF, 16'h0000); rsp_ready = 1'b0;
    #1 chk("bp_ready", req_ready, 4'b0100);
    cyc(); cyc();
    for (int k = 0; k < 5; k++) begin
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_id", rsp_id, 2);
      chk("bp_flags", {rsp_lt, rsp_gt, rsp_eq}, 3'b010);
      chk("bp_no_ready", req_ready, 4'b0000);
      cyc();
    end
    rsp_ready = 1'b1; req_valid = 4'b0000;
    cyc();
    chk("bp_release", rsp_valid, 0);

    // Serve 3, then 0 and 3 valid: pointer wraps to 0
    req_valid = 4'b1000; set_op(3, 16'h0010, 16'h0020);
    #1 chk("wrap_ready3", req_ready, 4'b1000);
    cyc(); req_valid = 4'b0000; cyc();
    chk("wrap_rsp3", rsp_id, 3);
    chk("wrap_flags3", {rsp_lt, rsp_gt, rsp_eq}, 3'b100);
    cyc();
    req_valid = 4'b1001;
    #1 chk("wrap_ready0", req_ready, 4'b0001);
    cyc(); req_valid = 4'b0000; cyc();
    chk("wrap_rsp0", rsp_id, 0);
    cyc();

    // Reset while in CMP drops the transaction
    req_valid = 4'b0010;
    #1 chk("rstcmp_ready", req_ready, 4'b0010);
    cyc();
    rst = 1'b1; req_valid = 4'b0000;
    cyc();
    rst = 1'b0;
    chk("rstcmp_idle", busy, 0);
    chk("rstcmp_nrsp", rsp_valid, 0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("rstcmp_silent", rsp_valid, 0);
    end
    req_valid = 4'b1111;
    #1 chk("rstcmp_prio0", req_ready, 4'b0001);
    req_valid = 4'b0000;

    // Random traffic with scoreboard
    n_tx = 0; n_rsp = 0; n_cyc = 0;
    cyc();
    while (n_rsp < 1000 && n_cyc < 20000) begin
      for (int i = 0; i < 4; i++) begin
        req_valid[i] = ($urandom_range(0, 3) != 0);
        case ($urandom_range(0, 3))
          0: set_op(i, 16'h0000, 16'hFFFF);
          1: begin
            req_a[i*W +: W] = W'($urandom);
            req_b[i*W +: W] = req_a[i*W +: W];
          end
          default: set_op(i, W'($urandom), W'($urandom));
        endcase
      end
      if (n_tx >= 1000) req_valid = 4'b0000;
      rsp_ready = ($urandom_range(0, 1) == 1);
      #1;
      if (req_ready != 4'b0000) begin
        chk("rand_ready_legal", {31'd0, $onehot(req_ready) && ((req_ready & ~req_valid) == 4'b0000)}, 1);
        gid = 0;
        for (int i = 0; i < 4; i++) if (req_ready[i]) gid = i;
        t.id = gid; t.a = req_a[gid*W +: W]; t.b = req_b[gid*W +: W];
        sb.push_back(t);
        n_tx++;
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          chk("rand_dup_rsp", 1, 0);
        end else begin
          t = sb.pop_front();
          chk("rand_id", rsp_id, t.id);
          chk("rand_flags", {rsp_lt, rsp_gt, rsp_eq}, {t.a < t.b, t.a > t.b, t.a == t.b});
        end
        n_rsp++;
      end
      n_cyc++;
      cyc();
    end
    chk("rand_count", n_rsp, 1000);
    chk("rand_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
